// File: rtl/wfg_wb_decoder.sv
// wfg_wb_decoder: Wishbone page decoder and response mux for the wfg subsystem.
// Decodes the upstream address into one of NUM_SLAVES pages, and forwards the
// access with registered strobes. The slave response is registered on the way
// back. A watchdog error-terminates accesses to slaves that never answer, and
// unmapped pages are also error-terminated. The first uncaptured error address
// is held in a sticky status until it is cleared.
module wfg_wb_decoder #(
  parameter int              BUSW       = 32,
  parameter int              PAGE_BITS  = 4,
  parameter int              NUM_SLAVES = 4,
  parameter int              BASE_PAGE  = 1,
  parameter int              TIMEOUT    = 16,
  parameter logic [BUSW-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  // upstream slave port
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [BUSW-1:0]            wbs_adr_i,
  input  logic [BUSW-1:0]            wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic                       wbs_err_o,
  output logic [BUSW-1:0]            wbs_dat_o,
  // downstream master port
  output logic                       m_cyc_o,
  output logic [NUM_SLAVES-1:0]      m_stb_o,
  output logic                       m_we_o,
  output logic [PAGE_BITS-1:0]       m_adr_o,
  output logic [BUSW-1:0]            m_dat_o,
  input  logic [NUM_SLAVES-1:0]      m_ack_i,
  input  logic [NUM_SLAVES*BUSW-1:0] m_dat_i,
  // sticky error status
  input  logic                       err_clr_i,
  output logic                       err_o,
  output logic [BUSW-1:0]            err_adr_o
);

  localparam int PAGE_W = BUSW - PAGE_BITS;
  localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT);

  localparam logic [PAGE_W-1:0] PAGE_FIRST = PAGE_W'(BASE_PAGE);
  localparam logic [PAGE_W-1:0] PAGE_END   = PAGE_W'(BASE_PAGE + NUM_SLAVES);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  // state and latched request
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  we_q, we_d;
  logic [BUSW-1:0]       adr_q, adr_d;
  logic [BUSW-1:0]       dat_q, dat_d;
  // registered bus outputs
  logic                  cyc_q, cyc_d;
  logic [NUM_SLAVES-1:0] stb_q, stb_d;
  logic                  ack_q, ack_d;
  logic                  berr_q, berr_d;
  logic [BUSW-1:0]       rdat_q, rdat_d;
  // sticky error status
  logic                  errf_q, errf_d;
  logic [BUSW-1:0]       erra_q, erra_d;

  // page decode of the live upstream address
  logic [PAGE_W-1:0]     dec_page;
  logic                  dec_mapped;
  logic [SEL_W-1:0]      dec_sel;

  // per-slave read data viewed as a packed array for the response mux
  logic [NUM_SLAVES-1:0][BUSW-1:0] s_dat;

  assign s_dat      = m_dat_i;
  assign dec_page   = wbs_adr_i[BUSW-1:PAGE_BITS];
  assign dec_mapped = (dec_page >= PAGE_FIRST) && (dec_page < PAGE_END);
  assign dec_sel    = SEL_W'(dec_page - PAGE_FIRST);

  // Access sequencing: capture, forward, wait for ack or timeout, respond.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    ack_d   = 1'b0;
    berr_d  = 1'b0;
    rdat_d  = rdat_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (wbs_cyc_i && wbs_stb_i) begin
          we_d  = wbs_we_i;
          adr_d = wbs_adr_i;
          dat_d = wbs_dat_i;
          sel_d = dec_sel;
          if (dec_mapped) begin
            state_d = S_ACTIVE;
            cyc_d   = 1'b1;
            stb_d   = NUM_SLAVES'(1) << dec_sel;
          end else begin
            // unmapped page: terminate with error without touching slaves
            state_d = S_ERR;
            berr_d  = 1'b1;
            rdat_d  = ERR_DATA;
          end
        end
      end
      S_ACTIVE: begin
        if (!wbs_cyc_i) begin
          // master abandoned the cycle: silent return, nothing logged
          state_d = S_IDLE;
          cyc_d   = 1'b0;
          stb_d   = '0;
          cnt_d   = '0;
        end else if (m_ack_i[sel_q]) begin
          // an ack in the last watchdog cycle still wins over the timeout
          state_d = S_RESP;
          ack_d   = 1'b1;
          rdat_d  = s_dat[sel_q];
          cyc_d   = 1'b0;
          stb_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
          berr_d  = 1'b1;
          rdat_d  = ERR_DATA;
          cyc_d   = 1'b0;
          stb_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky error capture; a capture in the same cycle as a clear takes priority.
  always_comb begin
    errf_d = errf_q;
    erra_d = erra_q;
    if (state_q == S_ERR && (!errf_q || err_clr_i)) begin
      errf_d = 1'b1;
      erra_d = adr_q;
    end else if (err_clr_i) begin
      errf_d = 1'b0;
      erra_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= '0;
      ack_q   <= 1'b0;
      berr_q  <= 1'b0;
      rdat_q  <= '0;
      errf_q  <= 1'b0;
      erra_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      berr_q  <= berr_d;
      rdat_q  <= rdat_d;
      errf_q  <= errf_d;
      erra_q  <= erra_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = berr_q;
  assign wbs_dat_o = rdat_q;
  assign m_cyc_o   = cyc_q;
  assign m_stb_o   = stb_q;
  assign m_we_o    = we_q;
  assign m_adr_o   = adr_q[PAGE_BITS-1:0];
  assign m_dat_o   = dat_q;
  assign err_o     = errf_q;
  assign err_adr_o = erra_q;

endmodule

// File: tb/tb_wfg_wb_decoder.sv
// Bench for wfg_wb_decoder: directed accesses push expected responses
// (kind, data, response cycle) into a scoreboard; a monitor pops and compares
// whenever the DUT presents ack or err.
module tb_wfg_wb_decoder;
  localparam int BUSW = 32;
  localparam int NS   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [BUSW-1:0]   wbs_adr_i = '0, wbs_dat_i = '0;
  logic              wbs_ack_o, wbs_err_o;
  logic [BUSW-1:0]   wbs_dat_o;
  logic              m_cyc_o, m_we_o;
  logic [NS-1:0]     m_stb_o;
  logic [3:0]        m_adr_o;
  logic [BUSW-1:0]   m_dat_o;
  logic [NS-1:0]     m_ack_i = '0;
  logic [NS*BUSW-1:0] m_dat_i = '0;
  logic              err_clr_i = 1'b0;
  logic              err_o;
  logic [BUSW-1:0]   err_adr_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit          sb_err[$];
  logic [31:0] sb_dat[$];
  int          sb_cyc[$];

  wfg_wb_decoder dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
    .err_clr_i(err_clr_i), .err_o(err_o), .err_adr_o(err_adr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // monitor: every ack/err must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && (wbs_ack_o || wbs_err_o)) begin
      check("ack_err_exclusive", 32'(wbs_ack_o & wbs_err_o), 32'd0);
      if (sb_err.size() == 0) begin
        check("unexpected_response", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        check("resp_kind_err", 32'(wbs_err_o), 32'(sb_err.pop_front()));
        check("resp_data", wbs_dat_o, sb_dat.pop_front());
        check("resp_cycle", 32'(cyc), 32'(sb_cyc.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      err_clr_i = 1'b0;
      m_ack_i   = '0;
    end
  endtask

  // One access. ack_dly: cycles after the first strobe cycle that the slave
  // acks (-1 = never). clr_at: access cycle in which err_clr_i is pulsed.
  task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                        input int ack_dly, input int clr_at, input bit exp_err,
                        input logic [31:0] exp_dat, input int exp_lat,
                        input logic [3:0] exp_stb, input int exp_stb_cycles);
    int  r, c, stb_cnt;
    bit  done;
    tick(1);
    r = cyc;
    sb_err.push_back(exp_err);
    sb_dat.push_back(exp_dat);
    sb_cyc.push_back(r + exp_lat);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wdat;
    c = 0; stb_cnt = 0; done = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      if (m_stb_o != '0) stb_cnt++;
      if (c == 1) begin
        check("strobe_first_cycle", 32'(m_stb_o), 32'(exp_stb));
        if (exp_stb != '0) begin
          check("m_adr", 32'(m_adr_o), 32'(adr[3:0]));
          check("m_we", 32'(m_we_o), 32'(we));
          check("m_dat", m_dat_o, wdat);
          check("m_cyc", 32'(m_cyc_o), 32'd1);
        end
      end
      m_ack_i   = (ack_dly >= 0 && c == 1 + ack_dly) ? exp_stb : 4'b0;
      err_clr_i = (c == clr_at);
      if (wbs_ack_o || wbs_err_o) done = 1;
    end
    if (!done) check("response_timeout", 32'(c), 32'(exp_lat));
    check("strobe_cycles", 32'(stb_cnt), 32'(exp_stb_cycles));
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   32'(wbs_ack_o), 32'd0);
    check({tag, "_err"},   32'(wbs_err_o), 32'd0);
    check({tag, "_dat"},   wbs_dat_o, 32'd0);
    check({tag, "_mcyc"},  32'(m_cyc_o), 32'd0);
    check({tag, "_mstb"},  32'(m_stb_o), 32'd0);
    check({tag, "_mwe"},   32'(m_we_o), 32'd0);
    check({tag, "_madr"},  32'(m_adr_o), 32'd0);
    check({tag, "_mdat"},  m_dat_o, 32'd0);
    check({tag, "_erro"},  32'(err_o), 32'd0);
    check({tag, "_eradr"}, err_adr_o, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < NS; k++) m_dat_i[k*BUSW +: BUSW] = 32'hCAFE_0000 | 32'(k);
    #12;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;

    // write to slave 1, ack 3 cycles after strobe
    access(1'b1, 32'h24, 32'h1234_5678, 3, 0, 0, 32'hCAFE_0001, 5, 4'b0010, 4);
    // zero-wait read of slave 2
    access(1'b0, 32'h38, 32'h0, 0, 0, 0, 32'hCAFE_0002, 2, 4'b0100, 1);
    // back-to-back zero-wait read of slave 0
    access(1'b0, 32'h1C, 32'h0, 0, 0, 0, 32'hCAFE_0000, 2, 4'b0001, 1);
    tick(2);
    check("dat_hold", wbs_dat_o, 32'hCAFE_0000);

    // unmapped: null page and beyond the map; first error kept
    access(1'b0, 32'h04, 32'h0, -1, 0, 1, 32'hDEAD_BEEF, 1, 4'b0000, 0);
    access(1'b0, 32'h50, 32'h0, -1, 0, 1, 32'hDEAD_BEEF, 1, 4'b0000, 0);
    tick(1);
    check("err_o_after_unmapped", 32'(err_o), 32'd1);
    check("err_adr_first_kept", err_adr_o, 32'h04);

    // watchdog timeout, then ack on the last allowed cycle
    access(1'b0, 32'h10, 32'h0, -1, 0, 1, 32'hDEAD_BEEF, 17, 4'b0001, 16);
    access(1'b0, 32'h10, 32'h0, 15, 0, 0, 32'hCAFE_0000, 17, 4'b0001, 16);
    tick(1);
    check("err_adr_after_timeout", err_adr_o, 32'h04);

    // abort mid-ACTIVE
    tick(1);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h30;
    @(negedge clk);
    check("abort_stb_on", 32'(m_stb_o), 32'b0100);
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk);
    check("abort_stb_off", 32'(m_stb_o), 32'd0);
    check("abort_cyc_off", 32'(m_cyc_o), 32'd0);
    tick(3);
    check("abort_err_o", 32'(err_o), 32'd1);
    check("abort_err_adr", err_adr_o, 32'h04);
    // counter must restart from zero after the abort
    access(1'b0, 32'h30, 32'h0, -1, 0, 1, 32'hDEAD_BEEF, 17, 4'b0100, 16);

    // async reset mid-ACTIVE
    tick(1);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h2C; wbs_dat_i = 32'hA5A5_5A5A;
    @(negedge clk);
    check("pre_reset_stb", 32'(m_stb_o), 32'b0010);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0;
    @(negedge clk); rst = 1'b0;

    // clear coinciding with a new capture: new error wins
    access(1'b0, 32'h70, 32'h0, -1, 0, 1, 32'hDEAD_BEEF, 1, 4'b0000, 0);
    tick(1);
    check("err_adr_70", err_adr_o, 32'h70);
    access(1'b0, 32'h60, 32'h0, -1, 1, 1, 32'hDEAD_BEEF, 1, 4'b0000, 0);
    tick(1);
    check("clr_coincide_err_o", 32'(err_o), 32'd1);
    check("clr_coincide_adr", err_adr_o, 32'h60);
    err_clr_i = 1'b1;
    tick(1);
    check("clr_err_o", 32'(err_o), 32'd0);
    check("clr_err_adr", err_adr_o, 32'd0);

    tick(3);
    check("scoreboard_empty", 32'(sb_err.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: actual=expired required=finished");
    $fatal(1);
  end
endmodule

// File: doc/wfg_wb_decoder.md
Name: wfg_wb_decoder

Overview:
Parametrised Wishbone address decoder and response multiplexer for the wfg subsystem. It generalises the fixed four-peripheral page decode to NUM_SLAVES pages, and registers both the request path and the response path. It adds a response-timeout watchdog, error termination for unmapped or non-responding pages, and a sticky error-capture status. It sits between the top-level Wishbone port and the wfg_core, stimulus, driver and interconnect register blocks.

Parameters:
BUSW, 32, data and address width
PAGE_BITS, 4, low address bits forwarded to a slave (page size = 2**PAGE_BITS bytes)
NUM_SLAVES, 4, number of decoded pages; slave k occupies page BASE_PAGE+k
BASE_PAGE, 1, first mapped page; page 0 (null page) is never mapped
TIMEOUT, 16, max cycles to wait for slave ack before error termination (>=2)
ERR_DATA, 32'hDEAD_BEEF, read data returned on error termination

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset; asynchronous and active-high
wbs_cyc_i  in  1  upstream cycle
wbs_stb_i  in  1  upstream strobe
wbs_we_i  in  1  upstream write enable
wbs_adr_i  in  BUSW  upstream address
wbs_dat_i  in  BUSW  upstream write data
wbs_ack_o  out  1  upstream ack, one-cycle pulse
wbs_err_o  out  1  upstream error, one-cycle pulse
wbs_dat_o  out  BUSW  upstream read data, valid with ack/err
m_cyc_o  out  1  downstream cycle (shared)
m_stb_o  out  NUM_SLAVES  per-slave strobe, one-hot or zero
m_we_o  out  1  downstream write enable (shared)
m_adr_o  out  PAGE_BITS  in-page address (shared)
m_dat_o  out  BUSW  write data (shared)
m_ack_i  in  NUM_SLAVES  per-slave ack
m_dat_i  in  NUM_SLAVES*BUSW  per-slave read data; slave k at [k*BUSW +: BUSW]
err_clr_i  in  1  clears sticky error status
err_o  out  1  sticky error flag
err_adr_o  out  BUSW  address of first uncleared error

Behaviour:
- Reset (async, wb_rst_i=1): state IDLE. All outputs 0: wbs_ack_o, wbs_err_o, wbs_dat_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, err_o, err_adr_o. Timeout counter 0.
- Decode: page = wbs_adr_i[BUSW-1:PAGE_BITS]. The access is mapped iff BASE_PAGE <= page < BASE_PAGE+NUM_SLAVES; sel = page-BASE_PAGE.
- IDLE: when wbs_cyc_i & wbs_stb_i, latch we, adr[PAGE_BITS-1:0], dat and sel.
  - Mapped -> ACTIVE.
  - Unmapped -> ERR.
- ACTIVE:
  - m_cyc_o=1 and m_stb_o[sel]=1 (registered; first asserted the cycle after the request is sampled). m_we_o, m_adr_o and m_dat_o hold the latched values.
  - Counter increments each cycle.
  - m_ack_i[sel]=1: capture m_dat_i slice sel into wbs_dat_o, drop m_cyc_o/m_stb_o, go to RESP.
  - Acks from non-selected slaves are ignored.
  - Counter reaches TIMEOUT-1 with no ack: drop m_cyc_o/m_stb_o, go to ERR. An ack arriving in that same cycle wins, and the state goes to RESP.
- RESP: wbs_ack_o=1 for exactly one cycle, then IDLE.
- ERR: wbs_err_o=1 for one cycle, wbs_dat_o=ERR_DATA. Sticky err_o is set and err_adr_o is loaded with the full latched address, but only if err_o is currently 0 (the first error is kept). Then IDLE.
- Latency: request sampled at cycle 0; slave strobe at cycle 1. A slave ack sampled at cycle n gives wbs_ack_o at cycle n+1. Minimum round trip is 2 cycles with a zero-wait slave.
- Unmapped access gives wbs_err_o at cycle 1. Timeout gives wbs_err_o at cycle TIMEOUT+1.
- Abort: wbs_cyc_i deasserting in ACTIVE returns to IDLE on the next edge. Downstream strobe drops, no ack/err is issued, no error is logged, and the counter clears.
- wbs_ack_o and wbs_err_o are never asserted together. wbs_dat_o holds its value between responses.
- RESP/ERR always return to IDLE. A new request can be sampled the cycle after the response, so back-to-back accesses have no extra idle cycle.
- err_clr_i clears err_o and err_adr_o to 0. If err_clr_i coincides with an ERR-state capture, the new error wins: err_o=1 and err_adr_o=new address.
- Writes and reads use identical flow. Write data from the slave is ignored except that wbs_dat_o is still updated.

Test Plan:
- Defaults. Write 0x1234_5678 to 0x24; slave 1 acks 3 cycles after its strobe. Expect m_stb_o=4'b0010, m_adr_o=4, m_we_o=1, and wbs_ack_o one cycle after m_ack_i[1].
- Read 0x38; slave 2 returns 0xCAFE_0002 with a zero-wait ack. Expect wbs_dat_o=0xCAFE_0002 with wbs_ack_o 2 cycles after the request, and no other strobe asserted.
- Read 0x04 (null page) and 0x50 (beyond the map). Expect wbs_err_o at cycle 1 with wbs_dat_o=0xDEAD_BEEF and no m_stb_o. Expect err_o=1 and err_adr_o=0x04 (first error kept).
- Read 0x10 with slave 0 never acking. Expect m_stb_o[0] high for 16 cycles, wbs_err_o at cycle 17, and wbs_ack_o never asserted. Repeat with the ack on the 16th cycle: expect wbs_ack_o and no error.
- Start a read of 0x30, then drop wbs_cyc_i after 2 cycles. Expect m_stb_o=0 next edge, no ack/err, and err_o unchanged. Assert wb_rst_i mid-ACTIVE: all outputs 0 immediately.
- Pulse err_clr_i in the same cycle as a new unmapped error at 0x60. Expect err_o=1 and err_adr_o=0x60. Pulse err_clr_i alone: expect err_o=0 and err_adr_o=0.
